// File: rtl/regfile_write_bank.sv
// regfile_write_bank
//   Write side of the integer register file. Holds x1..x31 in flops and
//   presents every register in parallel to the read-port multiplexers.
//   x0 reads as constant zero, and writes to it are accepted and dropped.
//   An optional clear engine zeroes x1..x31, one register per cycle.
//
//   Optional feature macro: REGBANK_CLEAR_EN
//     defined   : the clear FSM, sweep pointer, busy and clr_done are built
//     undefined : busy=0, clr_done=0 and wr_ready=1 are constant, and
//                 clr_req is ignored
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset; clears x1..x31 and the FSM
//     wr_valid   write-back request
//     wr_ready   bank can accept a write (NOT busy)
//     wr_addr    destination register index (5 bits)
//     wr_data    write data (XLEN bits)
//     clr_req    start a clear sweep; this level is sampled in IDLE
//     busy       clear sweep in progress
//     clr_done   one-cycle pulse in the cycle after the last sweep write
//     q0..q31    register contents, driven directly from flops
//
//   Clear FSM states
//     state    | meaning
//     ---------+-------------------------------------------------------
//     ST_IDLE  | normal operation; clr_req starts a sweep
//     ST_SWEEP | zero reg[ptr] each cycle; writes are stalled
//     ST_DONE  | one-cycle completion pulse; clr_req is ignored here

module regfile_write_bank #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            clr_req,
    output logic            busy,
    output logic            clr_done,
    output logic [XLEN-1:0] q0,
    output logic [XLEN-1:0] q1,
    output logic [XLEN-1:0] q2,
    output logic [XLEN-1:0] q3,
    output logic [XLEN-1:0] q4,
    output logic [XLEN-1:0] q5,
    output logic [XLEN-1:0] q6,
    output logic [XLEN-1:0] q7,
    output logic [XLEN-1:0] q8,
    output logic [XLEN-1:0] q9,
    output logic [XLEN-1:0] q10,
    output logic [XLEN-1:0] q11,
    output logic [XLEN-1:0] q12,
    output logic [XLEN-1:0] q13,
    output logic [XLEN-1:0] q14,
    output logic [XLEN-1:0] q15,
    output logic [XLEN-1:0] q16,
    output logic [XLEN-1:0] q17,
    output logic [XLEN-1:0] q18,
    output logic [XLEN-1:0] q19,
    output logic [XLEN-1:0] q20,
    output logic [XLEN-1:0] q21,
    output logic [XLEN-1:0] q22,
    output logic [XLEN-1:0] q23,
    output logic [XLEN-1:0] q24,
    output logic [XLEN-1:0] q25,
    output logic [XLEN-1:0] q26,
    output logic [XLEN-1:0] q27,
    output logic [XLEN-1:0] q28,
    output logic [XLEN-1:0] q29,
    output logic [XLEN-1:0] q30,
    output logic [XLEN-1:0] q31
);

    // x0 has no storage.
    logic [XLEN-1:0] regs [1:NREG-1];
    logic [NREG-1:0] wr_en;
    logic [NREG-1:0] clr_en;
    logic            accept;
    logic            unused_ok;

    assign accept = wr_valid & wr_ready;

    // One-hot write decode. Bit 0 is produced but has no register behind it,
    // so a write to x0 completes its handshake and the data is dropped.
    always_comb begin
        wr_en = '0;
        if (accept) begin
            wr_en[wr_addr] = 1'b1;
        end
    end

`ifdef REGBANK_CLEAR_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] state;
    logic [4:0] ptr;
    logic [4:0] ptr_eff;

    // ptr should never reach 0. If it somehow does, treat it as 1 so the
    // sweep cannot stall on the missing x0.
    assign ptr_eff = (ptr == 5'd0) ? 5'd1 : ptr;

    assign busy     = (state == ST_SWEEP);
    assign wr_ready = ~busy;
    assign clr_done = (state == ST_DONE);

    always_comb begin
        clr_en = '0;
        if (busy) begin
            clr_en[ptr_eff] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= 5'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_SWEEP;
                        ptr   <= 5'd1;
                    end
                end
                ST_SWEEP: begin
                    if (ptr_eff == 5'd31) begin
                        state <= ST_DONE;
                        ptr   <= 5'd1;
                    end else begin
                        ptr <= ptr_eff + 5'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= 5'd1;
                end
            endcase
        end
    end

    assign unused_ok = wr_en[0] ^ clr_en[0];
`else
    assign busy     = 1'b0;
    assign wr_ready = 1'b1;
    assign clr_done = 1'b0;
    assign clr_en   = '0;

    assign unused_ok = wr_en[0] ^ clr_en[0] ^ clr_req;
`endif

    // A sweep write and a port write can never land on the same edge,
    // because wr_ready is low for the whole sweep.
    always_ff @(posedge clk) begin
        for (int k = 1; k < NREG; k++) begin
            if (rst) begin
                regs[k] <= '0;
            end else if (clr_en[k]) begin
                regs[k] <= '0;
            end else if (wr_en[k]) begin
                regs[k] <= wr_data;
            end
        end
    end

    assign q0  = '0;
    assign q1  = regs[1];
    assign q2  = regs[2];
    assign q3  = regs[3];
    assign q4  = regs[4];
    assign q5  = regs[5];
    assign q6  = regs[6];
    assign q7  = regs[7];
    assign q8  = regs[8];
    assign q9  = regs[9];
    assign q10 = regs[10];
    assign q11 = regs[11];
    assign q12 = regs[12];
    assign q13 = regs[13];
    assign q14 = regs[14];
    assign q15 = regs[15];
    assign q16 = regs[16];
    assign q17 = regs[17];
    assign q18 = regs[18];
    assign q19 = regs[19];
    assign q20 = regs[20];
    assign q21 = regs[21];
    assign q22 = regs[22];
    assign q23 = regs[23];
    assign q24 = regs[24];
    assign q25 = regs[25];
    assign q26 = regs[26];
    assign q27 = regs[27];
    assign q28 = regs[28];
    assign q29 = regs[29];
    assign q30 = regs[30];
    assign q31 = regs[31];

endmodule

// File: tb/tb_regfile_write_bank.sv
// tb_regfile_write_bank
//   Self-checking bench for regfile_write_bank. A behavioural model tracks the
//   register contents and the clear sweep as a plain array plus a
//   "next register to clear" index. A negedge compare process checks every
//   output on every cycle against the model. The directed scenarios add a few
//   literal expectations, followed by a randomized phase.
//   The expected sweep behaviour follows REGBANK_CLEAR_EN.

module tb_regfile_write_bank;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic        clr_req  = 1'b0;
    logic        wr_ready;
    logic        busy;
    logic        clr_done;
    logic [31:0][31:0] qp;

`ifdef REGBANK_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cnt_nr   = 0;
    int cnt_done = 0;

    always #5 clk = ~clk;

    regfile_write_bank #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
        .q0(qp[0]),   .q1(qp[1]),   .q2(qp[2]),   .q3(qp[3]),
        .q4(qp[4]),   .q5(qp[5]),   .q6(qp[6]),   .q7(qp[7]),
        .q8(qp[8]),   .q9(qp[9]),   .q10(qp[10]), .q11(qp[11]),
        .q12(qp[12]), .q13(qp[13]), .q14(qp[14]), .q15(qp[15]),
        .q16(qp[16]), .q17(qp[17]), .q18(qp[18]), .q19(qp[19]),
        .q20(qp[20]), .q21(qp[21]), .q22(qp[22]), .q23(qp[23]),
        .q24(qp[24]), .q25(qp[25]), .q26(qp[26]), .q27(qp[27]),
        .q28(qp[28]), .q29(qp[29]), .q30(qp[30]), .q31(qp[31])
    );

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h t=%0t", name, idx, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    int          sweep_pos = 0;   // 0: no sweep; else next register to clear
    bit          m_done    = 1'b0;
    bit          checking  = 1'b0;
    bit          m_ready;
    bit          m_nd;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            sweep_pos = 0;
            m_done    = 1'b0;
            checking  = 1'b1;
        end else begin
            m_ready = !(CLEAR_EN && sweep_pos != 0);
            m_nd    = 1'b0;
            if (wr_valid && m_ready && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
            if (CLEAR_EN) begin
                if (sweep_pos != 0) begin
                    m_regs[sweep_pos] = '0;
                    if (sweep_pos == 31) begin
                        sweep_pos = 0;
                        m_nd      = 1'b1;
                    end else begin
                        sweep_pos = sweep_pos + 1;
                    end
                end else if (!m_done && clr_req) begin
                    sweep_pos = 1;
                end
            end
            m_done = m_nd;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            logic exp_ready;
            exp_ready = !(CLEAR_EN && sweep_pos != 0);
            chk("wr_ready", 0, {31'b0, wr_ready}, {31'b0, exp_ready});
            chk("busy",     0, {31'b0, busy},     {31'b0, !exp_ready});
            chk("clr_done", 0, {31'b0, clr_done}, {31'b0, m_done});
            for (int i = 0; i < 32; i++) chk("q", i, qp[i], m_regs[i]);
            if (!wr_ready) cnt_nr++;
            if (clr_done)  cnt_done++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        logic done_at_accept;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        for (int i = 0; i < 32; i++) chk("rst_q", i, qp[i], 32'h0);
        chk("rst_ready", 0, {31'b0, wr_ready}, 32'h1);
        chk("rst_busy",  0, {31'b0, busy},     32'h0);

        // basic writes
        wr_valid = 1'b1; wr_addr = 5'd5;  wr_data = 32'hDEADBEEF;
        tick();
        wr_addr = 5'd31; wr_data = 32'h1;
        chk("same_cycle_old", 31, qp[31], 32'h0);
        tick();
        wr_valid = 1'b0;
        chk("basic_q5",  5,  qp[5],  32'hDEADBEEF);
        chk("basic_q31", 31, qp[31], 32'h1);
        chk("basic_q6",  6,  qp[6],  32'h0);

        // x0 protection
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        chk("x0_ready", 0, {31'b0, wr_ready}, 32'h1);
        tick();
        wr_valid = 1'b0;
        chk("x0_q0", 0, qp[0], 32'h0);
        chk("x0_q5", 5, qp[5], 32'hDEADBEEF);

        // preload x1..x31 with their index, then sweep
        for (int i = 1; i < 32; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("preload_q17", 17, qp[17], 32'd17);
        cnt_nr = 0; cnt_done = 0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (40) tick();
        chk("sweep_notready_cycles", 0, 32'(cnt_nr),   CLEAR_EN ? 32'd31 : 32'd0);
        chk("sweep_done_pulses",     0, 32'(cnt_done), CLEAR_EN ? 32'd1  : 32'd0);
        chk("sweep_q20", 20, qp[20], CLEAR_EN ? 32'd0 : 32'd20);

        // write stall during sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        waited = 0;
        done_at_accept = 1'b0;
        while (!wr_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            chk("stall_timeout", 0, 32'(waited), 32'd0);
        end
        done_at_accept = clr_done;
        tick();
        wr_valid = 1'b0;
        chk("stall_cycles", 0, 32'(waited), CLEAR_EN ? 32'd31 : 32'd0);
        chk("stall_done_at_accept", 0, {31'b0, done_at_accept}, {31'b0, CLEAR_EN});
        chk("stall_q7", 7, qp[7], 32'h55);
        repeat (3) tick();

        // reset in the middle of a sweep
        wr_valid = 1'b1; wr_addr = 5'd3;  wr_data = 32'hAAAA;
        tick();
        wr_addr = 5'd30; wr_data = 32'hBBBB;
        tick();
        wr_valid = 1'b0;
        cnt_done = 0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 0, {31'b0, wr_ready}, 32'h1);
        chk("midrst_busy",  0, {31'b0, busy},     32'h0);
        chk("midrst_q30",   30, qp[30], 32'h0);
        chk("midrst_q3",    3,  qp[3],  32'h0);
        repeat (40) tick();
        chk("midrst_no_done", 0, 32'(cnt_done), 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            clr_req  = ($urandom_range(0, 59) == 0);
            rst      = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
